// File: rtl/tqvp_bus_master_if.sv
// Signal bundle between a command/response client, the bus master and
// one TinyQV-style peripheral.
interface tqvp_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
        input  rsp_ready, data_out, data_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output address, data_in, data_write_n, data_read_n
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
        output rsp_ready, data_out, data_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  address, data_in, data_write_n, data_read_n
    );
endinterface

// File: rtl/tqvp_bus_master.sv
// Single-command bus initiator for the TinyQV peripheral data interface.
// One command in flight; every transaction ends with a held response.
module tqvp_bus_master #(
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    tqvp_bus_master_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_state;
    logic [5:0]  r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic [31:0] r_rdata, w_rdata;
    logic        r_err, w_err;
    logic [1:0]  r_wr_n, w_wr_n;
    logic [1:0]  r_rd_n, w_rd_n;
    logic [7:0]  r_cnt, w_cnt;
    logic [31:0] w_mask;

    // The read strobe carries the size for the whole read.
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        unique case (r_rd_n)
            2'b00:   w_mask = 32'h0000_00FF;
            2'b01:   w_mask = 32'h0000_FFFF;
            default: w_mask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_rdata = r_rdata;
        w_err   = r_err;
        w_wr_n  = r_wr_n;
        w_rd_n  = r_rd_n;
        w_cnt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_addr  = bus.cmd_addr;
                    w_wdata = bus.cmd_wdata;
                    if (bus.cmd_size == 2'b11) begin
                        w_err   = 1'b1;
                        w_rdata = 32'd0;
                        w_state = S_RESP;
                    end else if (bus.cmd_write) begin
                        w_wr_n  = bus.cmd_size;
                        w_state = S_WRITE;
                    end else begin
                        w_rd_n  = bus.cmd_size;
                        w_cnt   = 8'd0;
                        w_state = S_READ;
                    end
                end
            end
            S_WRITE: begin
                w_wr_n  = 2'b11;
                w_err   = 1'b0;
                w_rdata = 32'd0;
                w_state = S_RESP;
            end
            S_READ: begin
                // A ready on the final allowed cycle still wins.
                if (bus.data_ready) begin
                    w_rdata = bus.data_out & w_mask;
                    w_err   = 1'b0;
                    w_rd_n  = 2'b11;
                    w_state = S_RESP;
                end else if (r_cnt == LP_LAST) begin
                    w_rdata = 32'd0;
                    w_err   = 1'b1;
                    w_rd_n  = 2'b11;
                    w_state = S_RESP;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= 6'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_wr_n  <= 2'b11;
            r_rd_n  <= 2'b11;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_rdata <= w_rdata;
            r_err   <= w_err;
            r_wr_n  <= w_wr_n;
            r_rd_n  <= w_rd_n;
            r_cnt   <= w_cnt;
        end
    end

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.rsp_valid    = (r_state == S_RESP);
    assign bus.rsp_rdata    = r_rdata;
    assign bus.rsp_err      = r_err;
    assign bus.address      = r_addr;
    assign bus.data_in      = r_wdata;
    assign bus.data_write_n = r_wr_n;
    assign bus.data_read_n  = r_rd_n;
endmodule
